// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, h/v counters, registered syncs,
// display qualifier and line/frame strobes, all presented from one registered state.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       Reset,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       inDisplayArea,
    output logic [9:0] CounterX,
    output logic [8:0] CounterY,
    output logic       pix_en,
    output logic       frame_start,
    output logic       line_start
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned Y_MAX        = 511;

    logic       pix_en_q, pix_en_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [8:0] counter_y_q, counter_y_d;
    logic       h_sync_q, h_sync_d;
    logic       v_sync_q, v_sync_d;
    logic       de_q, de_d;
    logic       frame_start_q, frame_start_d;
    logic       line_start_q, line_start_d;

    // Next-state counters, then every output derived from those next values
    // so counters and syncs/qualifiers always land in the same clk.
    always_comb begin
        pix_en_d      = (CLK_DIV == 1) ? 1'b1 : ~pix_en_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        counter_y_d   = counter_y_q;
        h_sync_d      = 1'b1;
        v_sync_d      = 1'b1;
        de_d          = 1'b0;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;

        if (pix_en_q) begin
            if (hcnt_q == 10'(H_TOTAL - 1)) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end

        counter_y_d = (vcnt_d > 10'(Y_MAX)) ? 9'(Y_MAX) : vcnt_d[8:0];
        h_sync_d    = !((hcnt_d >= 10'(H_SYNC_START)) && (hcnt_d < 10'(H_SYNC_END)));
        v_sync_d    = !((vcnt_d >= 10'(V_SYNC_START)) && (vcnt_d < 10'(V_SYNC_END)));
        de_d        = (hcnt_d < 10'(H_VISIBLE)) && (vcnt_d < 10'(V_VISIBLE));

        // hcnt can only reach 0 through a wrap, so this fires once per held pixel 0
        line_start_d  = pix_en_q && (hcnt_d == 10'd0);
        frame_start_d = line_start_d && (vcnt_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pix_en_q      <= 1'b0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            counter_y_q   <= 9'd0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            counter_y_q   <= counter_y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign vga_h_sync    = h_sync_q;
    assign vga_v_sync    = v_sync_q;
    assign inDisplayArea = de_q;
    assign CounterX      = hcnt_q;
    assign CounterY      = counter_y_q;
    assign pix_en        = pix_en_q;
    assign frame_start   = frame_start_q;
    assign line_start    = line_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and short-line builds checked every clk
// against an arithmetic raster model, plus strobe spacing and sync widths.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    // Short-line builds keep the full 525-line vertical so saturation is visible.
    localparam int SH_V = 4, SH_FP = 1, SH_S = 2, SH_BP = 1;
    localparam int SH_T = SH_V + SH_FP + SH_S + SH_BP;

    logic       b_hs, b_vs, b_de, b_pe, b_fs, b_ls;
    logic [9:0] b_x;
    logic [8:0] b_y;
    logic       s2_hs, s2_vs, s2_de, s2_pe, s2_fs, s2_ls;
    logic [9:0] s2_x;
    logic [8:0] s2_y;
    logic       s1_hs, s1_vs, s1_de, s1_pe, s1_fs, s1_ls;
    logic [9:0] s1_x;
    logic [8:0] s1_y;

    vga_sync_gen u_big (
        .clk(clk), .Reset(Reset), .vga_h_sync(b_hs), .vga_v_sync(b_vs),
        .inDisplayArea(b_de), .CounterX(b_x), .CounterY(b_y), .pix_en(b_pe),
        .frame_start(b_fs), .line_start(b_ls)
    );

    vga_sync_gen #(.CLK_DIV(2), .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP)) u_s2 (
        .clk(clk), .Reset(Reset), .vga_h_sync(s2_hs), .vga_v_sync(s2_vs),
        .inDisplayArea(s2_de), .CounterX(s2_x), .CounterY(s2_y), .pix_en(s2_pe),
        .frame_start(s2_fs), .line_start(s2_ls)
    );

    vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP)) u_s1 (
        .clk(clk), .Reset(Reset), .vga_h_sync(s1_hs), .vga_v_sync(s1_vs),
        .inDisplayArea(s1_de), .CounterX(s1_x), .CounterY(s1_y), .pix_en(s1_pe),
        .frame_start(s1_fs), .line_start(s1_ls)
    );

    int n_chk = 0;
    int n_fail = 0;
    int t = -1;                 // clks since the first edge that sampled Reset low
    int last_ls_b = -1, last_fs_s2 = -1, last_fs_s1 = -1;
    int hs_low_b = 0, vs_low_s2 = 0;

    // Expected {h_sync, v_sync, de, X, Y, pix_en, frame_start, line_start} at time t.
    function automatic logic [24:0] model(input int tt, input int cdiv, input int hv,
                                          input int hfp, input int hsw, input int hbp);
        int ht, p, h, l, y;
        bit pe, first;
        if (tt < 0) return {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0};
        ht = hv + hfp + hsw + hbp;
        if (cdiv == 2) begin
            p     = (tt + 1) / 2;
            pe    = (tt % 2 == 0);
            first = (p > 0) && (tt == 2 * p - 1);
        end else begin
            p     = tt;
            pe    = 1'b1;
            first = (p > 0);
        end
        h = p % ht;
        l = (p / ht) % 525;
        y = (l > 511) ? 511 : l;
        return {!(h >= hv + hfp && h < hv + hfp + hsw), !(l >= 490 && l < 492),
                (h < hv && l < 480), 10'(h), 9'(y), pe,
                (first && h == 0 && l == 0), (first && h == 0)};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
        end
    endtask

    // One clk: drive Reset for the coming edge, advance the model, compare.
    task automatic step(input logic rst);
        Reset = rst;
        @(posedge clk);
        t = Reset ? -1 : t + 1;
        #1;
        check("big_outputs", int'({b_hs, b_vs, b_de, b_x, b_y, b_pe, b_fs, b_ls}),
              int'(model(t, 2, 640, 16, 96, 48)));
        check("div2_outputs", int'({s2_hs, s2_vs, s2_de, s2_x, s2_y, s2_pe, s2_fs, s2_ls}),
              int'(model(t, 2, SH_V, SH_FP, SH_S, SH_BP)));
        check("div1_outputs", int'({s1_hs, s1_vs, s1_de, s1_x, s1_y, s1_pe, s1_fs, s1_ls}),
              int'(model(t, 1, SH_V, SH_FP, SH_S, SH_BP)));
        if (t < 0) begin
            last_ls_b = -1; last_fs_s2 = -1; last_fs_s1 = -1;
            hs_low_b = 0; vs_low_s2 = 0;
        end else begin
            if (b_ls === 1'b1) begin
                if (last_ls_b >= 0) check("big_line_period", t - last_ls_b, 1600);
                last_ls_b = t;
            end
            if (s2_fs === 1'b1) begin
                if (last_fs_s2 >= 0) check("div2_frame_period", t - last_fs_s2, 2 * SH_T * 525);
                else check("div2_first_frame", t, 2 * SH_T * 525 - 1);
                last_fs_s2 = t;
            end
            if (s1_fs === 1'b1) begin
                if (last_fs_s1 >= 0) check("div1_frame_period", t - last_fs_s1, SH_T * 525);
                else check("div1_first_frame", t, SH_T * 525);
                last_fs_s1 = t;
            end
            if (b_hs === 1'b0) begin
                if (hs_low_b == 0) check("big_hsync_fall_x", int'(b_x), 656);
                hs_low_b++;
            end else if (hs_low_b != 0) begin
                check("big_hsync_width", hs_low_b, 192);
                hs_low_b = 0;
            end
            if (s2_vs === 1'b0) begin
                if (vs_low_s2 == 0) check("div2_vsync_fall_x", int'(s2_x), 0);
                vs_low_s2++;
            end else if (vs_low_s2 != 0) begin
                check("div2_vsync_width", vs_low_s2, 2 * SH_T * 2);
                check("div2_vsync_rise_x", int'(s2_x), 0);
                vs_low_s2 = 0;
            end
        end
    endtask

    initial begin
        int r;
        // Reset held for 5 clks, then two short frames plus several full lines.
        repeat (5) step(1'b1);
        repeat (17000) step(1'b0);
        // Randomly placed mid-frame resets of random length.
        for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(3000, 100));
            repeat (r) step(1'b0);
            r = int'($urandom_range(3, 1));
            repeat (r) step(1'b1);
        end
        // Run long enough after the last reset for each build to restart its frame.
        repeat (9000) step(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
